// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
// It latches the winner's byte and baud select, then sequences the transmitter's start/active/done handshake.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [3*N_REQ-1:0]   req_baud,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic [N_REQ-1:0]     err,
  output logic                 busy,
  output logic                 tx_start,
  output logic [7:0]           tx_byte,
  output logic [2:0]           tx_baud_sel,
  input  logic                 tx_active,
  input  logic                 tx_done
);

  localparam int PW = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACT, WAIT_DONE, HOLDOFF} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     rr_ptr, rr_ptr_next, win;
  logic              win_valid;
  logic [CW-1:0]     count, count_next;
  logic [N_REQ-1:0]  grant_next, done_next, err_next;
  logic              busy_next, tx_start_next;
  logic [7:0]        tx_byte_next;
  logic [2:0]        tx_baud_next;

  // Scan from farthest to nearest so the requester closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    win       = rr_ptr;
    win_valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        win       = PW'((int'(rr_ptr) + k) % N_REQ);
        win_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    count_next    = count;
    grant_next    = grant;
    done_next     = '0;
    err_next      = '0;
    tx_start_next = 1'b0;
    tx_byte_next  = tx_byte;
    tx_baud_next  = tx_baud_sel;
    case (state)
      IDLE: begin
        if (win_valid && !tx_active && !tx_done) begin
          grant_next      = '0;
          grant_next[win] = 1'b1;
          tx_byte_next    = req_data[int'(win)*8 +: 8];
          tx_baud_next    = req_baud[int'(win)*3 +: 3];
          tx_start_next   = 1'b1;
          rr_ptr_next     = win;
          state_next      = LAUNCH;
        end
      end
      LAUNCH: begin
        count_next = '0;
        state_next = WAIT_ACT;
      end
      WAIT_ACT: begin
        // tx_done here is unexpected and deliberately ignored; only tx_active counts as an ack.
        if (tx_active) begin
          state_next = WAIT_DONE;
        end else if (count == CW'(ACK_TIMEOUT)) begin
          err_next   = grant;
          grant_next = '0;
          state_next = HOLDOFF;
        end else begin
          count_next = count + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          done_next  = grant;
          grant_next = '0;
          state_next = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (!tx_done && !tx_active) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= PW'(N_REQ - 1);
      count       <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      tx_baud_sel <= '0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      count       <= count_next;
      grant       <= grant_next;
      done        <= done_next;
      err         <= err_next;
      busy        <= busy_next;
      tx_start    <= tx_start_next;
      tx_byte     <= tx_byte_next;
      tx_baud_sel <= tx_baud_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a small transmitter model plus a transaction-level round-robin reference.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int ACK = 15;

  logic           clk, rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [3*N-1:0] req_baud;
  logic [N-1:0]   grant, done, err;
  logic           busy, tx_start;
  logic [7:0]     tx_byte;
  logic [2:0]     tx_baud_sel;
  wire            tx_active, tx_done;

  logic act_m, done_m, force_act, force_done;
  assign tx_active = act_m | force_act;
  assign tx_done   = done_m | force_done;

  int checks, fails, rr_model;
  int start_cnt, done_cnt, err_cnt, viol;
  int mode, act_delay, frame_len, done_len;  // mode 0 normal, 1 never acks, 2 raises only tx_done

  uart_tx_arbiter #(.N_REQ(N), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_baud(req_baud),
    .grant(grant), .done(done), .err(err), .busy(busy), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_baud_sel(tx_baud_sel), .tx_active(tx_active), .tx_done(tx_done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Transmitter model, driven 1ns after each rising edge.
  initial begin
    int phase, cnt;
    act_m = 0; done_m = 0; phase = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        phase = 0; act_m = 0; done_m = 0;
      end else begin
        case (phase)
          0: if (tx_start === 1'b1 && mode != 1) begin cnt = act_delay; phase = 1; end
          1: if (cnt == 0) begin
               if (mode == 2) begin done_m = 1; cnt = done_len - 1; phase = 3; end
               else begin act_m = 1; cnt = frame_len; phase = 2; end
             end else cnt--;
          2: if (cnt == 0) begin act_m = 0; done_m = 1; cnt = done_len - 1; phase = 3; end
             else cnt--;
          default: if (cnt == 0) begin done_m = 0; phase = 0; end else cnt--;
        endcase
      end
    end
  end

  // Event counters and protocol-violation tally, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((grant & (grant - 1'b1)) !== '0) viol++;
        if (tx_start === 1'b1 && (tx_done === 1'b1 || tx_active === 1'b1)) viol++;
        if (tx_start === 1'b1) start_cnt++;
        if (done !== '0) done_cnt++;
        if (err !== '0) err_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int pred_winner(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One full transaction: acceptance, frame, completion pulse, return to idle.
  task automatic do_frame(input string tag, input int exp_w, input bit exp_err,
                          input bit drop_mid, input bit drop_after);
    logic [N-1:0] oh;
    logic [7:0]   eb;
    logic [2:0]   ebd;
    int n, td;
    bit stable;
    oh = '0; oh[exp_w] = 1'b1;
    eb = req_data[8*exp_w +: 8]; ebd = req_baud[3*exp_w +: 3];
    n = 0;
    while (grant === '0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (grant !== oh) begin
      $display("FAIL %s grant: got %b expected %b", tag, grant, oh); fails++;
      if (grant === '0) return;
    end
    checks++;
    if (tx_start !== 1'b1 || tx_byte !== eb || tx_baud_sel !== ebd) begin
      $display("FAIL %s launch: start %b byte %02h baud %0d expected 1 %02h %0d",
               tag, tx_start, tx_byte, tx_baud_sel, eb, ebd); fails++;
    end
    if (drop_mid) req[exp_w] = 1'b0;
    stable = 1; n = 0; td = -1;
    while (done === '0 && err === '0 && n < 300) begin
      if (tx_byte !== eb || tx_baud_sel !== ebd) stable = 0;
      if (tx_done === 1'b1 && td < 0) td = n;
      @(negedge clk); n++;
    end
    checks++;
    if (exp_err ? (err !== oh || done !== '0) : (done !== oh || err !== '0)) begin
      $display("FAIL %s completion: done %b err %b expected %s on %b", tag, done, err,
               exp_err ? "err" : "done", oh); fails++;
    end
    checks++;
    if (grant !== '0) begin
      $display("FAIL %s grant_release: got %b expected 0", tag, grant); fails++;
    end
    checks++;
    if (exp_err && n != ACK + 2) begin
      $display("FAIL %s timeout_latency: got %0d expected %0d", tag, n, ACK + 2); fails++;
    end else if (!exp_err && n - td != 1) begin
      $display("FAIL %s done_latency: got %0d expected 1", tag, n - td); fails++;
    end
    $display("frame %s: requester %0d byte %02h baud %0d %s after %0d cycles",
             tag, exp_w, eb, ebd, exp_err ? "err" : "done", n);
    if (drop_after) req[exp_w] = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== '0 || err !== '0) begin
      $display("FAIL %s pulse_width: done %b err %b expected 0", tag, done, err); fails++;
    end
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      if (tx_byte !== eb || tx_baud_sel !== ebd) stable = 0;
      @(negedge clk); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL %s busy_drop: got %b expected 0", tag, busy); fails++;
    end
    checks++;
    if (!stable) begin
      $display("FAIL %s hold_stable: byte/baud changed, expected %02h/%0d held", tag, eb, ebd); fails++;
    end
    rr_model = exp_w;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({grant, done, err, busy, tx_start, tx_byte, tx_baud_sel} !== '0) begin
      $display("FAIL reset_outputs: grant %b done %b err %b busy %b start %b byte %02h baud %0d expected all 0",
               grant, done, err, busy, tx_start, tx_byte, tx_baud_sel); fails++;
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== '0 || tx_start !== 1'b0) begin
      $display("FAIL reset_idle: busy %b grant %b start %b expected 0", busy, grant, tx_start); fails++;
    end
    rr_model = N - 1;
  endtask

  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    int s0, v0;
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = 8'h10 + 8'(i);
      req_baud[3*i +: 3] = 3'($urandom_range(0, 7));
    end
    s0 = start_cnt; v0 = viol;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) do_frame("contention", order[i], 0, 0, 0);
    req = '0;
    checks++;
    if (start_cnt - s0 != 5) begin
      $display("FAIL contention_starts: got %0d expected 5", start_cnt - s0); fails++;
    end
    checks++;
    if (viol != v0) begin
      $display("FAIL contention_protocol: got %0d violations expected 0", viol - v0); fails++;
    end
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt; frame_len = 6;
    req_data[7:0] = 8'hA5; req_baud[2:0] = 3'b101;
    req = 4'b0001;
    do_frame("single", 0, 0, 0, 1);
    checks++;
    if (done_cnt - d0 != 1) begin
      $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); fails++;
    end
  endtask

  task automatic test_fairness();
    req = 4'b0100;
    do_frame("fair_a", 2, 0, 0, 1);
    req = 4'b0101;
    do_frame("fair_b", 0, 0, 0, 1);
    do_frame("fair_c", 2, 0, 0, 1);
  endtask

  task automatic test_timeout();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    mode = 1; req = 4'b0010;
    do_frame("timeout", 1, 1, 0, 1);
    mode = 2; act_delay = 2; done_len = 2; req = 4'b0010;
    do_frame("spurious_done", 1, 1, 0, 1);
    mode = 0; act_delay = 1; done_len = 1; req = 4'b0010;
    do_frame("after_timeout", 1, 0, 0, 1);
    checks++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 2) begin
      $display("FAIL timeout_counts: done %0d err %0d expected 1 2", done_cnt - d0, err_cnt - e0); fails++;
    end
  endtask

  task automatic test_two_cycle_done();
    int d0, v0;
    d0 = done_cnt; v0 = viol; done_len = 2;
    req = 4'b1000;
    do_frame("done2_a", 3, 0, 0, 0);
    do_frame("done2_b", 3, 0, 0, 1);
    done_len = 1;
    checks++;
    if (done_cnt - d0 != 2 || viol != v0) begin
      $display("FAIL two_cycle_done: done %0d violations %0d expected 2 0", done_cnt - d0, viol - v0); fails++;
    end
  endtask

  task automatic test_idle_block();
    int s0;
    s0 = start_cnt;
    force_done = 1; req = 4'b0001;
    repeat (5) @(negedge clk);
    checks++;
    if (grant !== '0 || start_cnt != s0) begin
      $display("FAIL idle_block_done: grant %b starts %0d expected 0 0", grant, start_cnt - s0); fails++;
    end
    force_done = 0; force_act = 1;
    repeat (5) @(negedge clk);
    checks++;
    if (grant !== '0 || start_cnt != s0) begin
      $display("FAIL idle_block_active: grant %b starts %0d expected 0 0", grant, start_cnt - s0); fails++;
    end
    force_act = 0;
    do_frame("idle_release", 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    int w;
    for (int it = 0; it < 24; it++) begin
      req_data  = $urandom;
      req_baud  = 12'($urandom);
      mask      = 4'($urandom_range(1, 15));
      mode      = ($urandom_range(0, 5) == 0) ? 1 : 0;
      act_delay = $urandom_range(0, 3);
      frame_len = $urandom_range(1, 10);
      done_len  = $urandom_range(1, 2);
      w = pred_winner(mask, rr_model);
      req = mask;
      do_frame("random", w, mode == 1, 1'($urandom_range(0, 1)), 1);
    end
    mode = 0; act_delay = 1; done_len = 1; req = '0;
  endtask

  task automatic test_reset_mid_frame();
    int n, d0, e0;
    mode = 0; frame_len = 30; act_delay = 1;
    req = 4'b0100;
    n = 0;
    while (tx_active !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 4'b0100) begin
      $display("FAIL midframe_grant: got %b expected 0100", grant); fails++;
    end
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    checks++;
    if (grant !== '0 || done !== '0 || err !== '0 || tx_start !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL midframe_async_reset: grant %b done %b err %b start %b busy %b expected all 0",
               grant, done, err, tx_start, busy); fails++;
    end
    repeat (2) @(negedge clk);
    req = 4'b1001; rr_model = N - 1; frame_len = 4;
    rst_n = 1;
    do_frame("post_reset_a", 0, 0, 0, 1);
    do_frame("post_reset_b", 3, 0, 0, 1);
    checks++;
    if (done_cnt - d0 != 2 || err_cnt != e0) begin
      $display("FAIL midframe_no_pulse: done %0d err %0d expected 2 0", done_cnt - d0, err_cnt - e0); fails++;
    end
  endtask

  initial begin
    checks = 0; fails = 0; start_cnt = 0; done_cnt = 0; err_cnt = 0; viol = 0;
    rst_n = 0; req = '0; req_data = '0; req_baud = '0;
    force_act = 0; force_done = 0;
    mode = 0; act_delay = 1; frame_len = 4; done_len = 1;
    test_reset();
    test_contention();
    test_single();
    test_fairness();
    test_timeout();
    test_two_cycle_done();
    test_idle_block();
    test_random();
    test_reset_mid_frame();
    checks++;
    if (viol != 0) begin
      $display("FAIL protocol_violations: got %0d expected 0", viol); fails++;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
